// File: rtl/shift_unit_arbiter_if.sv
// Request/response bundle for the shared shift engine.
// master: two requesters plus result consumer; slave: the engine.
interface shift_unit_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [SHW-1:0]   req0_amt;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [SHW-1:0]   req1_amt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_amt,
    output req1_valid, req1_op, req1_a, req1_amt,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_amt,
    input  req1_valid, req1_op, req1_a, req1_amt,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin shared iterative shift/rotate engine, one bit per cycle.
// Ports: clk, reset_n (sync, active low), bus (slave: req0/req1/rsp).
module shift_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input logic clk,
  input logic reset_n,
  shift_unit_arbiter_if.slave bus
);
  localparam logic [2:0] OP_SHL  = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHRA = 3'd2;
  localparam logic [2:0] OP_ROL  = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             err_q, err_d;

  logic             gnt0, gnt1;
  logic [2:0]       op_s;
  logic [WIDTH-1:0] a_s;
  logic [SHW-1:0]   amt_s;
  logic             legal_s;
  logic [WIDTH-1:0] step;

  // On contention the port that did not own the last result wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
      gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  assign op_s    = gnt1 ? bus.req1_op  : bus.req0_op;
  assign a_s     = gnt1 ? bus.req1_a   : bus.req0_a;
  assign amt_s   = gnt1 ? bus.req1_amt : bus.req0_amt;
  assign legal_s = (op_s <= OP_ROR);

  always_comb begin
    step = data_q;
    case (op_q)
      OP_SHL:  step = {data_q[WIDTH-2:0], 1'b0};
      OP_SHR:  step = {1'b0, data_q[WIDTH-1:1]};
      OP_SHRA: step = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      OP_ROL:  step = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      OP_ROR:  step = {data_q[0], data_q[WIDTH-1:1]};
      default: step = data_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 | gnt1) begin
          op_d   = op_s;
          data_d = a_s;
          cnt_d  = amt_s;
          id_d   = gnt1;
          err_d  = ~legal_s;
          // Illegal ops and zero shifts skip straight to the result.
          if (legal_s && (amt_s != '0)) state_d = BUSY;
          else                          state_d = DONE;
        end
      end
      BUSY: begin
        data_d = step;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
          last_d  = id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      op_q    <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed bench for shift_unit_arbiter.
// Drives both requesters and checks results, latency and arbitration.
module tb_shift_unit_arbiter;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  shift_unit_arbiter_if #(.WIDTH(32), .SHW(5)) bus ();

  shift_unit_arbiter #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit p, input logic [2:0] op,
                       input logic [31:0] a, input logic [4:0] amt);
    if (!p) begin
      bus.req0_valid = 1'b1;
      bus.req0_op    = op;
      bus.req0_a     = a;
      bus.req0_amt   = amt;
    end else begin
      bus.req1_valid = 1'b1;
      bus.req1_op    = op;
      bus.req1_a     = a;
      bus.req1_amt   = amt;
    end
  endtask

  task automatic issue(input bit p, input logic [2:0] op,
                       input logic [31:0] a, input logic [4:0] amt,
                       input int lat, input logic [31:0] exp_d,
                       input logic exp_e);
    int n;
    drive(p, op, a, amt);
    #1;
    check_eq("req_ready", p ? bus.req1_ready : bus.req0_ready, 1);
    @(posedge clk); #1;
    if (!p) bus.req0_valid = 1'b0;
    else    bus.req1_valid = 1'b0;
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", n, lat);
    check_eq("rsp_data", bus.rsp_data, exp_d);
    check_eq("rsp_id", {31'd0, bus.rsp_id}, {31'd0, p});
    check_eq("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_e});
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check_eq("rsp_drop", {31'd0, bus.rsp_valid}, 0);
  endtask

  initial begin
    logic [31:0] got_d [3];
    logic        got_i [3];
    int          ngot;
    bit          both;
    bit          seen;
    n_cmp = 0;
    n_bad = 0;
    reset_n = 1'b0;
    bus.req0_valid = 0; bus.req0_op = 0;
    bus.req0_a = 0;     bus.req0_amt = 0;
    bus.req1_valid = 0; bus.req1_op = 0;
    bus.req1_a = 0;     bus.req1_amt = 0;
    bus.rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'd0, bus.rsp_valid}, 0);
    check_eq("rst_data", bus.rsp_data, 0);
    check_eq("rst_id", {31'd0, bus.rsp_id}, 0);
    check_eq("rst_err", {31'd0, bus.rsp_err}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ROL by 4 on port 0
    issue(0, 3'd3, 32'hF0F0F0F0, 5'd4, 5, 32'h0F0F0F0F, 0);
    consume();

    // SHRA / SHR by 31 on port 1
    issue(1, 3'd2, 32'h80000000, 5'd31, 32, 32'hFFFFFFFF, 0);
    consume();
    issue(1, 3'd1, 32'h80000000, 5'd31, 32, 32'h00000001, 0);
    consume();

    // Contention: both requesters held valid
    drive(0, 3'd4, 32'h12345678, 5'd16);
    drive(1, 3'd0, 32'h00000001, 5'd4);
    bus.rsp_ready = 1'b1;
    ngot = 0;
    both = 0;
    for (int c = 0; c < 120 && ngot < 3; c++) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) both = 1;
      if (bus.rsp_valid) begin
        got_d[ngot] = bus.rsp_data;
        got_i[ngot] = bus.rsp_id;
        ngot++;
        if (ngot == 3) begin
          bus.req0_valid = 0;
          bus.req1_valid = 0;
        end
      end
      @(posedge clk);
    end
    #1;
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    bus.rsp_ready = 1'b0;
    check_eq("rr_count", ngot, 3);
    check_eq("rr_both", {31'd0, both}, 0);
    if (ngot == 3) begin
      check_eq("rr_id0", {31'd0, got_i[0]}, 0);
      check_eq("rr_d0", got_d[0], 32'h56781234);
      check_eq("rr_id1", {31'd0, got_i[1]}, 1);
      check_eq("rr_d1", got_d[1], 32'h00000010);
      check_eq("rr_id2", {31'd0, got_i[2]}, 0);
      check_eq("rr_d2", got_d[2], 32'h56781234);
    end
    @(posedge clk); #1;

    // amt = 0 with back-pressure
    issue(0, 3'd3, 32'hAAAAAAAA, 5'd0, 1, 32'hAAAAAAAA, 0);
    for (int i = 0; i < 5; i++) begin
      bus.req0_valid = 1;
      bus.req1_valid = 1;
      #1;
      check_eq("hold_valid", {31'd0, bus.rsp_valid}, 1);
      check_eq("hold_data", bus.rsp_data, 32'hAAAAAAAA);
      check_eq("hold_rdy0", {31'd0, bus.req0_ready}, 0);
      check_eq("hold_rdy1", {31'd0, bus.req1_ready}, 0);
      @(posedge clk); #1;
    end
    bus.req0_valid = 0;
    bus.req1_valid = 0;
    consume();
    bus.req1_valid = 1;
    #1;
    check_eq("idle_rdy1", {31'd0, bus.req1_ready}, 1);
    bus.req1_valid = 0;
    @(posedge clk); #1;

    // Illegal opcode
    issue(0, 3'd7, 32'hDEADBEEF, 5'd9, 1, 32'hDEADBEEF, 1);
    consume();

    // Reset in the 10th BUSY cycle of SHL 1 by 20
    drive(0, 3'd0, 32'h00000001, 5'd20);
    #1;
    check_eq("ab_rdy0", {31'd0, bus.req0_ready}, 1);
    @(posedge clk); #1;
    bus.req0_valid = 0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    check_eq("ab_valid", {31'd0, bus.rsp_valid}, 0);
    check_eq("ab_data", bus.rsp_data, 0);
    check_eq("ab_id", {31'd0, bus.rsp_id}, 0);
    check_eq("ab_err", {31'd0, bus.rsp_err}, 0);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.rsp_valid) seen = 1;
      @(posedge clk); #1;
    end
    check_eq("ab_norsp", {31'd0, seen}, 0);
    drive(1, 3'd0, 32'h00000001, 5'd4);
    drive(0, 3'd0, 32'h00000001, 5'd20);
    #1;
    check_eq("ab_rdy1", {31'd0, bus.req1_ready}, 0);
    issue(0, 3'd0, 32'h00000001, 5'd20, 21, 32'h00100000, 0);
    bus.req1_valid = 0;
    consume();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shared multi-cycle shift/rotate engine serving two requesters, e.g. port 0 = ALU and port 1 = address/immediate path.
- Round-robin arbitration decides which requester is granted; one operation is in flight at a time.
- Executes SHL, SHR, SHRA, ROL and ROR iteratively, one bit position per cycle, then holds the result until it is accepted.
- Sits beside the single-cycle rotate datapath as the low-area sequenced alternative for the CPU's shift instructions.

Parameters:
- WIDTH, 32, data width of operand and result.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset, sampled on rising clk.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_op  input  3  opcode, requester 0.
- req0_a  input  WIDTH  operand, requester 0.
- req0_amt  input  SHW  shift amount, requester 0.
- req1_valid, req1_ready, req1_op, req1_a, req1_amt: same as port 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  index of the requester that owns the result.
- rsp_data  output  WIDTH  result.
- rsp_err  output  1  opcode was illegal.

Behaviour:
- Opcodes:
  - 000 SHL, zero fill.
  - 001 SHR, zero fill.
  - 010 SHRA, sign fill.
  - 011 ROL.
  - 100 ROR.
  - 101-111 illegal: rsp_data = a unchanged, rsp_err = 1, behaves as amt = 0.
- States are IDLE, BUSY and DONE.
- Reset (reset_n = 0 at a clk edge):
  - state becomes IDLE and last_grant becomes 1, so port 0 wins first.
  - rsp_valid, rsp_id, rsp_err, rsp_data and the internal counter all become 0.
  - An in-flight operation is discarded with no response.
- req_ready is combinational:
  - It is asserted only in IDLE and only for the granted port.
  - When only one port has valid set, that port is granted.
  - When both ports have valid set, the port not equal to last_grant is granted.
  - Outside IDLE, both req_ready outputs are 0.
- Accept edge (valid & ready, in IDLE):
  - Captures op, a, amt and the requester id into working registers; counter = amt.
  - Next state is BUSY if amt != 0 and the op is legal; otherwise DONE.
- BUSY, at each edge:
  - The working register moves by one bit in the op's direction.
  - SHRA replicates bit WIDTH-1; rotates feed back the bit that was shifted out.
  - counter decrements by 1.
  - When counter == 1 before the edge, next state is DONE.
- Latency: rsp_valid rises amt+1 cycles after the accept edge (1 cycle for amt = 0), so maximum latency is 32.
- DONE:
  - rsp_valid = 1, and rsp_data, rsp_id and rsp_err are stable.
  - On an edge with rsp_valid & rsp_ready, the next state is IDLE, rsp_valid drops, and last_grant is set to rsp_id.
  - While rsp_ready = 0, all rsp_* outputs hold.
- No new request is accepted in the cycle a response is consumed. Throughput is one operation per amt+2 cycles minimum.
- Requesters must hold valid and payload stable until ready is returned. A valid deassert before grant is legal and cancels the request.
- amt = 31 with ROL is equivalent to ROR by 1. There is no amt = 32 case.
- reset_n low during BUSY or DONE aborts at that edge. The first grant after the abort goes to port 0 if it is requesting.

Test Plan:
- Port 0: ROL, a = F0F0F0F0, amt = 4 -> req0_ready = 1 in the accept cycle; rsp_valid 5 cycles later; rsp_data = 0F0F0F0F, rsp_id = 0, rsp_err = 0.
- Port 1: SHRA, a = 80000000, amt = 31 -> rsp_data = FFFFFFFF after 32 cycles. Then port 1: SHR with the same a and amt -> rsp_data = 00000001.
- Both ports valid continuously:
  - port 0 = ROR 12345678 by 16; port 1 = SHL 00000001 by 4.
  - Required responses, in order: id 0 with 56781234, id 1 with 00000010, id 0 again.
  - req_ready is never asserted for both ports in the same cycle.
- amt = 0 ROL AAAAAAAA, with rsp_ready held low for 5 cycles -> rsp_valid one cycle after accept; rsp_data = AAAAAAAA stable throughout; both req_ready = 0 until the release cycle; return to IDLE one cycle after rsp_ready = 1.
- Illegal op 111, a = DEADBEEF, amt = 9 -> one-cycle latency, rsp_data = DEADBEEF, rsp_err = 1.
- SHL 1 by 20, with reset_n pulsed low in the 10th BUSY cycle -> no rsp_valid; outputs are 0 on the next cycle. A new request then completes correctly with port 0 granted first.
